lpc_host: RTL



---
 rtl/lpc_host.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lpc_host.sv
// lpc_host: LPC I/O read/write initiator.
// Turns one system-side request into a complete LPC I/O cycle on
// lpc_frame/lpc_data. It absorbs SYNC wait states, reports error SYNCs, and
// aborts the cycle when the target never produces a terminal SYNC.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only while the FSM is IDLE, so at
// most one cycle is outstanding. The request fields are sampled only on that
// edge. Each accepted request produces exactly one response: a one-cycle
// rsp_valid pulse in DONE, with rsp_rdata/rsp_err valid in that same cycle.
// A reset discards the request that is in flight without producing a response.
module lpc_host #(
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic        lpc_clk,
  input  logic        lpc_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        lpc_frame,
  inout  wire  [3:0]  lpc_data,
  output logic [4:0]  dbg_state
);

  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(SYNC_TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  localparam logic [3:0] CT_READ  = 4'b0000;
  localparam logic [3:0] CT_WRITE = 4'b0010;
  localparam logic [3:0] SYNC_OK  = 4'b0000;
  localparam logic [3:0] SYNC_ERR = 4'b1010;

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_START  = 5'd1,
    S_CTDIR  = 5'd2,
    S_ADDR0  = 5'd3,
    S_ADDR1  = 5'd4,
    S_ADDR2  = 5'd5,
    S_ADDR3  = 5'd6,
    S_WDATA0 = 5'd7,
    S_WDATA1 = 5'd8,
    S_TARH0  = 5'd9,
    S_TARH1  = 5'd10,
    S_SYNC   = 5'd11,
    S_RDATA0 = 5'd12,
    S_RDATA1 = 5'd13,
    S_TART0  = 5'd14,
    S_TART1  = 5'd15,
    S_ABORT  = 5'd16,
    S_DONE   = 5'd17
  } state_t;

  state_t state;
  state_t next_state;

  // Latched request.
  logic        write_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;

  // Per-cycle collection: read data nibbles and the error SYNC flag.
  logic [7:0]  data_q;
  logic        err_q;

  // SYNC wait counter and ABORT length counter.
  logic [CW-1:0] wait_cnt;
  logic [1:0]    abort_cnt;

  // Bus drive decoded from the registered state.
  logic       drive_en;
  logic [3:0] drive_val;

  logic accept;
  logic sync_ok;
  logic sync_err;
  logic sync_term;

  assign accept    = req_valid && req_ready;
  assign sync_ok   = (lpc_data == SYNC_OK);
  assign sync_err  = (lpc_data == SYNC_ERR);
  assign sync_term = sync_ok || sync_err;

  assign lpc_data  = drive_en ? drive_val : 4'bzzzz;
  assign dbg_state = state;

  // State register; reset returns to IDLE at once, releasing the bus.
  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-state bus/handshake outputs.
  always_comb begin
    next_state = state;
    drive_en   = 1'b0;
    drive_val  = 4'b1111;
    lpc_frame  = 1'b1;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = S_START;
      end
      S_START: begin
        lpc_frame  = 1'b0;
        drive_en   = 1'b1;
        drive_val  = 4'b0000;
        next_state = S_CTDIR;
      end
      S_CTDIR: begin
        drive_en   = 1'b1;
        drive_val  = write_q ? CT_WRITE : CT_READ;
        next_state = S_ADDR0;
      end
      S_ADDR0: begin
        drive_en   = 1'b1;
        drive_val  = addr_q[15:12];
        next_state = S_ADDR1;
      end
      S_ADDR1: begin
        drive_en   = 1'b1;
        drive_val  = addr_q[11:8];
        next_state = S_ADDR2;
      end
      S_ADDR2: begin
        drive_en   = 1'b1;
        drive_val  = addr_q[7:4];
        next_state = S_ADDR3;
      end
      S_ADDR3: begin
        drive_en   = 1'b1;
        drive_val  = addr_q[3:0];
        next_state = write_q ? S_WDATA0 : S_TARH0;
      end
      S_WDATA0: begin
        drive_en   = 1'b1;
        drive_val  = wdata_q[3:0];
        next_state = S_WDATA1;
      end
      S_WDATA1: begin
        drive_en   = 1'b1;
        drive_val  = wdata_q[7:4];
        next_state = S_TARH0;
      end
      S_TARH0: begin
        drive_en   = 1'b1;
        drive_val  = 4'b1111;
        next_state = S_TARH1;
      end
      S_TARH1: begin
        next_state = S_SYNC;
      end
      S_SYNC: begin
        // Error SYNC follows the same path as ready; only the flag differs.
        if (sync_term) begin
          next_state = write_q ? S_TART0 : S_RDATA0;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_ABORT;
        end
      end
      S_RDATA0: next_state = S_RDATA1;
      S_RDATA1: next_state = S_TART0;
      S_TART0:  next_state = S_TART1;
      S_TART1:  next_state = S_DONE;
      S_ABORT: begin
        lpc_frame = 1'b0;
        drive_en  = 1'b1;
        drive_val = 4'b1111;
        if (abort_cnt == 2'd3) next_state = S_DONE;
      end
      S_DONE: begin
        rsp_valid  = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Request latch on acceptance.
  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      write_q <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // SYNC wait counting; the only way into SYNC is from TARH1, so clear there.
  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      wait_cnt <= '0;
    end else if (state == S_TARH1) begin
      wait_cnt <= '0;
    end else if (state == S_SYNC && !sync_term) begin
      wait_cnt <= wait_cnt + WAIT_ONE;
    end
  end

  // ABORT lasts four cycles; the only way in is from SYNC.
  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      abort_cnt <= 2'd0;
    end else if (state == S_SYNC) begin
      abort_cnt <= 2'd0;
    end else if (state == S_ABORT) begin
      abort_cnt <= abort_cnt + 2'd1;
    end
  end

  // Collect the error flag and read nibbles (low nibble first).
  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      data_q <= 8'h00;
      err_q  <= 1'b0;
    end else if (accept) begin
      data_q <= 8'h00;
      err_q  <= 1'b0;
    end else begin
      if (state == S_SYNC && sync_term) err_q <= sync_err;
      if (state == S_RDATA0) data_q[3:0] <= lpc_data;
      if (state == S_RDATA1) data_q[7:4] <= lpc_data;
    end
  end

  // Response registers load on the way into DONE and hold until the next one.
  always_ff @(posedge lpc_clk or posedge lpc_rst) begin
    if (lpc_rst) begin
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else if (state == S_TART1) begin
      rsp_rdata <= data_q;
      rsp_err   <= err_q;
    end else if (state == S_ABORT && abort_cnt == 2'd3) begin
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b1;
    end
  end

endmodule
